// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types, default timing constants and sizing helpers
//                for the push-button conditioning slice.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Contents:
//    rpt_state_t        auto-repeat FSM state encoding
//    BTN_DEBOUNCE_10MS  debounce window at 100 MHz
//    BTN_REPEAT_500MS   press-to-first-repeat delay at 100 MHz
//    BTN_PERIOD_100MS   repeat period at 100 MHz
//    cnt_width()        counter width able to hold 0 .. n-1 (never below 1)
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_t;

  localparam int BTN_DEBOUNCE_10MS = 1_000_000;
  localparam int BTN_REPEAT_500MS  = 50_000_000;
  localparam int BTN_PERIOD_100MS  = 10_000_000;

  // Width needed to count 0 .. n-1. A terminal count of 0 still needs a
  // one-bit register, so the result never drops below 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_channel
//  Description : One push-button channel: 2-flop synchronizer, debounce
//                filter, press/release edge pulses and hold-to-repeat FSM.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk          in   system clock
//    reset        in   synchronous, active-high reset
//    btn_raw      in   asynchronous raw button input
//    btn_level    out  debounced level
//    btn_press    out  1-cycle pulse, first cycle btn_level reads 1
//    btn_release  out  1-cycle pulse, first cycle btn_level reads 0
//    btn_rpt      out  1-cycle auto-repeat pulse while held
// ============================================================================
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = BTN_REPEAT_500MS,
  parameter int REPEAT_PERIOD   = BTN_PERIOD_100MS,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_rpt
);

  localparam int c_db_w  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_rpt_w = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                     REPEAT_DELAY : REPEAT_PERIOD);

  localparam logic [c_db_w-1:0]  c_db_last    = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rpt_w-1:0] c_delay_last = c_rpt_w'(REPEAT_DELAY - 1);
  localparam logic [c_rpt_w-1:0] c_per_last   = c_rpt_w'(REPEAT_PERIOD - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic [c_db_w-1:0] r_db_cnt;
  logic              r_level;
  logic              r_press;
  logic              r_release;

  rpt_state_t         r_state;
  rpt_state_t         w_state_nxt;
  logic [c_rpt_w-1:0] r_rpt_cnt;
  logic [c_rpt_w-1:0] w_rpt_cnt_nxt;
  logic               w_rpt;

  // --------------------------------------------------------------------------
  // Synchronizer, debounce and edge pulses. The pulses are registered on the
  // same edge that flips the level, so each lines up with the first cycle of
  // the new level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_sync2 == r_level) begin
        // Any agreeing sample restarts the window, which rejects short glitches.
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_last) begin
        r_db_cnt  <= '0;
        r_level   <= ~r_level;
        r_press   <= ~r_level;
        r_release <= r_level;
      end else begin
        r_db_cnt <= r_db_cnt + c_db_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Auto-repeat FSM. The counter runs from the cycle after the press, so the
  // pulse decoded at the terminal count lands exactly REPEAT_DELAY (then
  // REPEAT_PERIOD) cycles after the previous event.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RPT_IDLE;
      r_rpt_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_rpt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_rpt         = 1'b0;

    case (r_state)
      RPT_IDLE: begin
        w_rpt_cnt_nxt = '0;
        if (r_press) begin
          w_state_nxt = RPT_DELAY;
        end
      end
      RPT_DELAY: begin
        if (r_rpt_cnt == c_delay_last) begin
          w_rpt         = 1'b1;
          w_rpt_cnt_nxt = '0;
          w_state_nxt   = RPT_RUN;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + c_rpt_w'(1);
        end
      end
      RPT_RUN: begin
        if (r_rpt_cnt == c_per_last) begin
          w_rpt         = 1'b1;
          w_rpt_cnt_nxt = '0;
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt + c_rpt_w'(1);
        end
      end
      default: begin
        w_state_nxt   = RPT_IDLE;
        w_rpt_cnt_nxt = '0;
      end
    endcase

    // A released button (including its release-pulse cycle) or a masked
    // channel never repeats; the FSM drops straight back to idle.
    if (!r_level || !REPEAT_EN) begin
      w_state_nxt   = RPT_IDLE;
      w_rpt_cnt_nxt = '0;
      w_rpt         = 1'b0;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_rpt     = w_rpt;

endmodule : btn_channel
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : N_BTN independent push-button conditioning channels plus a
//                registered event stream (press or repeat) for the counter FSM.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk          in   [1]      100 MHz system clock
//    reset        in   [1]      synchronous, active-high reset
//    btn_raw      in   [N_BTN]  asynchronous raw button inputs
//    btn_level    out  [N_BTN]  debounced levels
//    btn_press    out  [N_BTN]  1-cycle pulse per accepted 0->1 transition
//    btn_release  out  [N_BTN]  1-cycle pulse per accepted 1->0 transition
//    btn_rpt      out  [N_BTN]  1-cycle auto-repeat pulses while held
//    btn_evt      out  [N_BTN]  registered btn_press | btn_rpt
// ============================================================================
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 2,
  parameter int               DEBOUNCE_CYCLES = BTN_DEBOUNCE_10MS,
  parameter int               REPEAT_DELAY    = BTN_REPEAT_500MS,
  parameter int               REPEAT_PERIOD   = BTN_PERIOD_100MS,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_rpt,
  output logic [N_BTN-1:0] btn_evt
);

  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_rpt;
  logic [N_BTN-1:0] r_evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (w_press[i]),
      .btn_release (btn_release[i]),
      .btn_rpt     (w_rpt[i])
    );
  end

  // Registered so the consumer sees a glitch-free, flop-driven event bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt <= '0;
    end else begin
      r_evt <= w_press | w_rpt;
    end
  end

  assign btn_press = w_press;
  assign btn_rpt   = w_rpt;
  assign btn_evt   = r_evt;

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Self-checking bench for btn_conditioner. Directed scenarios
//                followed by random button activity, compared every cycle
//                against a behavioural model built from event timestamps.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int         N_BTN = 2;
  localparam int         D     = 4;
  localparam int         R     = 10;
  localparam int         T     = 3;
  localparam logic [1:0] MASK  = 2'b01;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_rpt;
  logic [N_BTN-1:0] btn_evt;

  btn_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (R),
    .REPEAT_PERIOD   (T),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_rpt     (btn_rpt),
    .btn_evt     (btn_evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state (values valid just after the most recent edge).
  logic [1:0] m_s1 = '0, m_s2 = '0;
  logic [1:0] m_lvl = '0, m_press = '0, m_rel = '0, m_rpt = '0, m_evt = '0;
  int         m_run   [2];
  int         m_pedge [2];
  bit         m_pvalid[2];

  // Counters of DUT pulses on channel 0 over a scenario window.
  int cnt_press0, cnt_rel0, cnt_rpt0, cnt_lvl0, cnt_press_both;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Model of one clock edge: the input needs two edges to reach the filter,
  // a level is accepted after D consecutive disagreeing samples, and repeats
  // are scheduled purely from the timestamp of the last press.
  task automatic model_edge(input logic [1:0] raw, input logic rst);
    logic [1:0] seen;
    int         d;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_rpt = '0; m_evt = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_run[ch] = 0;
        m_pvalid[ch] = 1'b0;
      end
    end else begin
      m_evt   = m_press | m_rpt;
      seen    = m_s2;
      m_s2    = m_s1;
      m_s1    = raw;
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (seen[ch] != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == D) begin
            m_run[ch]  = 0;
            m_lvl[ch]  = ~m_lvl[ch];
            if (m_lvl[ch]) begin
              m_press[ch]  = 1'b1;
              m_pedge[ch]  = cyc;
              m_pvalid[ch] = 1'b1;
            end else begin
              m_rel[ch]    = 1'b1;
              m_pvalid[ch] = 1'b0;
            end
          end
        end else begin
          m_run[ch] = 0;
        end
        d = cyc - m_pedge[ch];
        if (MASK[ch] && m_lvl[ch] && m_pvalid[ch] && d >= R && ((d - R) % T) == 0)
          m_rpt[ch] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    cyc++;
    model_edge(raw, rst);
    #1;
    check_value("level",   32'(btn_level),   32'(m_lvl));
    check_value("press",   32'(btn_press),   32'(m_press));
    check_value("release", 32'(btn_release), 32'(m_rel));
    check_value("rpt",     32'(btn_rpt),     32'(m_rpt));
    check_value("evt",     32'(btn_evt),     32'(m_evt));
    check_value("press_rpt_excl", 32'(btn_press & btn_rpt), 32'(0));
    cnt_press0 += int'(btn_press[0]);
    cnt_rel0   += int'(btn_release[0]);
    cnt_rpt0   += int'(btn_rpt[0]);
    cnt_lvl0   += int'(btn_level[0]);
    if (btn_press == 2'b11) cnt_press_both++;
  endtask

  task automatic hold(input logic [1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_press0 = 0; cnt_rel0 = 0; cnt_rpt0 = 0; cnt_lvl0 = 0; cnt_press_both = 0;
  endtask

  initial begin
    logic [1:0] rv;
    int         len;
    logic       rs;

    for (int ch = 0; ch < 2; ch++) begin
      m_run[ch] = 0; m_pedge[ch] = 0; m_pvalid[ch] = 1'b0;
    end
    btn_raw = '0;
    reset   = 1'b1;
    clear_counts();

    for (int k = 0; k < 3; k++) step(2'b00, 1'b1);
    hold(2'b00, 3);

    // Clean press held 30 cycles: press at edge 5, repeats at +10, +13, ...
    clear_counts();
    hold(2'b01, 30);
    check_value("s1_press_count", 32'(cnt_press0), 32'(1));
    check_value("s1_rpt_count",   32'(cnt_rpt0),   32'(5));
    hold(2'b00, 12);

    // Bounce: toggles every 2 cycles for 12 cycles, then stays high.
    clear_counts();
    for (int k = 0; k < 12; k++) step((k % 4) < 2 ? 2'b01 : 2'b00, 1'b0);
    hold(2'b01, 10);
    check_value("s2_press_count",   32'(cnt_press0), 32'(1));
    check_value("s2_release_count", 32'(cnt_rel0),   32'(0));
    hold(2'b00, 12);

    // Glitch shorter than the debounce window.
    clear_counts();
    hold(2'b01, 3);
    hold(2'b00, 12);
    check_value("s3_level_count", 32'(cnt_lvl0), 32'(0));
    check_value("s3_press_count", 32'(cnt_press0), 32'(0));

    // Release while still in the repeat delay.
    clear_counts();
    hold(2'b01, 8);
    hold(2'b00, 12);
    check_value("s4_release_count", 32'(cnt_rel0), 32'(1));
    check_value("s4_rpt_count",     32'(cnt_rpt0), 32'(0));

    // Reset while repeating, button held throughout.
    clear_counts();
    hold(2'b01, 25);
    step(2'b01, 1'b1);
    check_value("s5_reset_outputs",
                32'({btn_level, btn_press, btn_release, btn_rpt, btn_evt}), 32'(0));
    step(2'b01, 1'b1);
    clear_counts();
    hold(2'b01, 6);
    check_value("s5_repress", 32'(cnt_press0), 32'(1));
    hold(2'b01, 10);
    hold(2'b00, 12);

    // Both channels together; only channel 0 repeats.
    clear_counts();
    hold(2'b11, 30);
    check_value("s6_press_both", 32'(cnt_press_both), 32'(1));
    hold(2'b00, 12);

    // Random activity with occasional resets and short glitches.
    for (int seg = 0; seg < 150; seg++) begin
      rv  = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 25));
      rs  = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < len; k++) step(rv, rs && (k < 2));
    end
    hold(2'b00, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_btn_conditioner
`default_nettype wire
